rv32i_writeback: RTL

Final pipeline stage of the RV32I core: accepts one retiring instruction per handshake from the memory stage, waits for load data when needed, sign/zero-extends loads, and drives the write port (`o_wr`, `o_rd_addr`, `o_rd`) of the 32-entry base register file. It owns the load-wait stall and a load watchdog, and emits one retire pulse per accepted instruction.

---
 rtl/rv32i_writeback_if.sv | 38 +++
 rtl/rv32i_writeback.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rv32i_writeback_if.sv
// rv32i_writeback_if: memory-stage to writeback bundle plus the
// register-file write port and the status pulses of the writeback stage.
interface rv32i_writeback_if;
  logic        i_valid;
  logic        o_stall;
  logic [4:0]  i_rd_addr;
  logic        i_wr_rd;
  logic [1:0]  i_rd_src;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc;
  logic [31:0] i_csr_data;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lsb;
  logic        i_load_ack;
  logic [31:0] i_load_data;
  logic        o_wr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic        o_retire;
  logic        o_load_timeout;
  logic        o_misaligned;

  modport master (
    output i_valid, i_rd_addr, i_wr_rd, i_rd_src,
    output i_alu_result, i_pc, i_csr_data,
    output i_funct3, i_addr_lsb, i_load_ack, i_load_data,
    input  o_stall, o_wr, o_rd_addr, o_rd,
    input  o_retire, o_load_timeout, o_misaligned
  );

  modport slave (
    input  i_valid, i_rd_addr, i_wr_rd, i_rd_src,
    input  i_alu_result, i_pc, i_csr_data,
    input  i_funct3, i_addr_lsb, i_load_ack, i_load_data,
    output o_stall, o_wr, o_rd_addr, o_rd,
    output o_retire, o_load_timeout, o_misaligned
  );
endinterface

// File: rtl/rv32i_writeback.sv
// rv32i_writeback: final RV32I stage, load wait/extend, regfile write.
// Optional macro RV32I_WB_MISALIGN_EN enables misaligned-load detection.
module rv32i_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  rv32i_writeback_if.slave bus
);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic          ld_wr_q, ld_wr_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    ld_lsb_q, ld_lsb_d;
  logic          wr_q, wr_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_q, rd_d;
  logic          retire_q, retire_d;
  logic          timeout_q, timeout_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] cnt_inc;
  logic          mis_ld;

  function automatic logic [31:0] load_ext(
    input logic [2:0]  f3,
    input logic [1:0]  lsb,
    input logic [31:0] data
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lsb[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = data;
    endcase
  endfunction

  // Next-state, capture and output-register computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_wr_d   = ld_wr_q;
    ld_f3_d   = ld_f3_q;
    ld_lsb_d  = ld_lsb_q;
    wr_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    retire_d  = 1'b0;
    timeout_d = 1'b0;
    mis_d     = 1'b0;
    cnt_inc   = cnt_q + CW'(1);
`ifdef RV32I_WB_MISALIGN_EN
    mis_ld = (bus.i_funct3[1:0] == 2'b01 && bus.i_addr_lsb[0])
          || (bus.i_funct3[1] && bus.i_addr_lsb != 2'd0);
`else
    mis_ld = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_rd_src == 2'd1) begin
            if (mis_ld) begin
              mis_d    = 1'b1;
              retire_d = 1'b1;
            end else begin
              ld_rd_d  = bus.i_rd_addr;
              ld_wr_d  = bus.i_wr_rd;
              ld_f3_d  = bus.i_funct3;
              ld_lsb_d = bus.i_addr_lsb;
              cnt_d    = '0;
              state_d  = WAIT_LOAD;
            end
          end else begin
            retire_d  = 1'b1;
            wr_d      = bus.i_wr_rd && bus.i_rd_addr != 5'd0;
            rd_addr_d = bus.i_rd_addr;
            case (bus.i_rd_src)
              2'd2:    rd_d = bus.i_pc + 32'd4;
              2'd3:    rd_d = bus.i_csr_data;
              default: rd_d = bus.i_alu_result;
            endcase
          end
        end
      end
      default: begin
        if (bus.i_load_ack) begin
          retire_d  = 1'b1;
          wr_d      = ld_wr_q && ld_rd_q != 5'd0;
          rd_addr_d = ld_rd_q;
          rd_d      = load_ext(ld_f3_q, ld_lsb_q,
                               bus.i_load_data);
          state_d   = IDLE;
        end else if (cnt_inc == CW'(LOAD_TIMEOUT)) begin
          retire_d  = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_wr_q   <= 1'b0;
      ld_f3_q   <= '0;
      ld_lsb_q  <= '0;
      wr_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
      retire_q  <= 1'b0;
      timeout_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_wr_q   <= ld_wr_d;
      ld_f3_q   <= ld_f3_d;
      ld_lsb_q  <= ld_lsb_d;
      wr_q      <= wr_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
      retire_q  <= retire_d;
      timeout_q <= timeout_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.o_stall        = (state_q == WAIT_LOAD);
  assign bus.o_wr           = wr_q;
  assign bus.o_rd_addr      = rd_addr_q;
  assign bus.o_rd           = rd_q;
  assign bus.o_retire       = retire_q;
  assign bus.o_load_timeout = timeout_q;
  assign bus.o_misaligned   = mis_q;
endmodule
